// File: rtl/rr_reg_arbiter.sv
// Round-robin arbiter sharing one W-bit register among N requesters, with HOLD cool-down cycles after each grant.
// Optional RR_GNT_CNT_EN adds a saturating 16-bit grant counter output (gnt_cnt).
module rr_reg_arbiter #(
    parameter int N    = 4,
    parameter int W    = 8,
    parameter int HOLD = 2,
    localparam int PW  = $clog2(N),
    localparam int CW  = (HOLD > 1) ? $clog2(HOLD) : 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req,
    input  logic [N*W-1:0] data_in,
    output logic [N-1:0]   gnt,
    output logic [W-1:0]   q,
    output logic           q_valid,
    output logic [PW-1:0]  owner,
    output logic           busy
`ifdef RR_GNT_CNT_EN
    ,
    output logic [15:0]    gnt_cnt
`endif
);

    typedef enum logic [1:0] {IDLE, GRANT, COOL} state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] ptr_q, ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [N-1:0]  gnt_q, gnt_d;
    logic [W-1:0]  data_q, data_d;
    logic          qv_q, qv_d;
    logic [PW-1:0] owner_q, owner_d;

    logic          found;
    logic [PW-1:0] win;
    logic [PW:0]   sum;
    logic [PW-1:0] cand;

    // Search from the pointer upward with wrap-around; first set bit wins.
    always_comb begin
        found = 1'b0;
        win   = '0;
        sum   = '0;
        cand  = '0;
        for (int i = 0; i < N; i++) begin
            sum = {1'b0, ptr_q} + (PW+1)'(i);
            if (sum >= (PW+1)'(N)) begin
                sum = sum - (PW+1)'(N);
            end
            cand = sum[PW-1:0];
            if (!found && req[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        gnt_d   = '0;
        qv_d    = 1'b0;
        data_d  = data_q;
        owner_d = owner_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    gnt_d[win] = 1'b1;
                    data_d     = data_in[win*W +: W];
                    owner_d    = win;
                    qv_d       = 1'b1;
                    ptr_d      = (win == PW'(N-1)) ? '0 : win + PW'(1);
                    state_d    = GRANT;
                end
            end
            GRANT: begin
                if (HOLD == 0) begin
                    state_d = IDLE;
                end else begin
                    state_d = COOL;
                    cnt_d   = CW'(HOLD-1);
                end
            end
            COOL: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            cnt_q   <= '0;
            gnt_q   <= '0;
            data_q  <= '0;
            qv_q    <= 1'b0;
            owner_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
            data_q  <= data_d;
            qv_q    <= qv_d;
            owner_q <= owner_d;
        end
    end

    assign gnt     = gnt_q;
    assign q       = data_q;
    assign q_valid = qv_q;
    assign owner   = owner_q;
    assign busy    = (state_q != IDLE);

`ifdef RR_GNT_CNT_EN
    logic [15:0] gcnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            gcnt_q <= '0;
        end else if (state_q == IDLE && found && gcnt_q != 16'hFFFF) begin
            gcnt_q <= gcnt_q + 16'd1;
        end
    end

    assign gnt_cnt = gcnt_q;
`endif

endmodule

// File: tb/tb_rr_reg_arbiter.sv
// Bench for rr_reg_arbiter: HOLD=2 and HOLD=0 instances, grant scoreboard plus inline state checks.
module tb_rr_reg_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  req0, req1;
    logic [31:0] data_in;
    logic [3:0]  gnt0, gnt1;
    logic [7:0]  q0, q1;
    logic        qv0, qv1;
    logic [1:0]  owner0, owner1;
    logic        busy0, busy1;
`ifdef RR_GNT_CNT_EN
    logic [15:0] gcnt0, gcnt1;
`endif

    typedef struct {
        logic [3:0] gnt;
        logic [7:0] q;
        logic [1:0] owner;
        int         gap;
    } exp_t;

    exp_t exp0[$];
    exp_t exp1[$];
    exp_t e0, e1;
    int   tests = 0;
    int   failed = 0;
    int   cyc = 0;
    int   last0 = 0;
    int   last1 = 0;

    rr_reg_arbiter #(.N(4), .W(8), .HOLD(2)) u0 (
        .clk(clk), .rst(rst), .req(req0), .data_in(data_in),
        .gnt(gnt0), .q(q0), .q_valid(qv0), .owner(owner0), .busy(busy0)
`ifdef RR_GNT_CNT_EN
        , .gnt_cnt(gcnt0)
`endif
    );

    rr_reg_arbiter #(.N(4), .W(8), .HOLD(0)) u1 (
        .clk(clk), .rst(rst), .req(req1), .data_in(data_in),
        .gnt(gnt1), .q(q1), .q_valid(qv1), .owner(owner1), .busy(busy1)
`ifdef RR_GNT_CNT_EN
        , .gnt_cnt(gcnt1)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic [3:0] g, input logic [7:0] d, input logic [1:0] o, input int gap);
        exp_t e;
        e.gnt = g; e.q = d; e.owner = o; e.gap = gap;
        return e;
    endfunction

    always @(negedge clk) begin
        if (rst && (gnt0 != 4'b0 || qv0)) begin
            if (exp0.size() == 0) begin
                tests++; failed++;
                $display("FAIL u0_unexpected_grant: got gnt=%b q=%0h expected none", gnt0, q0);
            end else begin
                e0 = exp0.pop_front();
                chk("u0_gnt", 32'(gnt0), 32'(e0.gnt));
                chk("u0_q", 32'(q0), 32'(e0.q));
                chk("u0_owner", 32'(owner0), 32'(e0.owner));
                chk("u0_q_valid", 32'(qv0), 32'd1);
                if (e0.gap >= 0) chk("u0_gap", 32'(cyc - last0), 32'(e0.gap));
                last0 = cyc;
            end
        end
    end

    always @(negedge clk) begin
        if (rst && (gnt1 != 4'b0 || qv1)) begin
            if (exp1.size() == 0) begin
                tests++; failed++;
                $display("FAIL u1_unexpected_grant: got gnt=%b q=%0h expected none", gnt1, q1);
            end else begin
                e1 = exp1.pop_front();
                chk("u1_gnt", 32'(gnt1), 32'(e1.gnt));
                chk("u1_q", 32'(q1), 32'(e1.q));
                chk("u1_owner", 32'(owner1), 32'(e1.owner));
                chk("u1_q_valid", 32'(qv1), 32'd1);
                if (e1.gap >= 0) chk("u1_gap", 32'(cyc - last1), 32'(e1.gap));
                last1 = cyc;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy0 || busy1) begin
            step();
            n++;
            if (n > 20) begin
                tests++; failed++;
                $display("FAIL wait_idle: got busy after %0d cycles expected idle", n);
                return;
            end
        end
    endtask

    initial begin
        rst     = 1'b0;
        req0    = 4'b1111;
        req1    = 4'b0000;
        data_in = {8'h44, 8'hA5, 8'h22, 8'h11};

        // Reset state, requests ignored while held in reset.
        #3;
        chk("rst_gnt", 32'(gnt0), 32'd0);
        chk("rst_q", 32'(q0), 32'd0);
        chk("rst_q_valid", 32'(qv0), 32'd0);
        chk("rst_owner", 32'(owner0), 32'd0);
        chk("rst_busy", 32'(busy0), 32'd0);
        step(); step();
        chk("rst_gnt_held", 32'(gnt0), 32'd0);
        chk("rst_busy_held", 32'(busy0), 32'd0);
        exp0.push_back(mk(4'b0001, 8'h11, 2'd0, -1));
        rst = 1'b1;
        step();
        req0 = 4'b0000;
        wait_idle();

        // Single request from requester 2.
        exp0.push_back(mk(4'b0100, 8'hA5, 2'd2, -1));
        req0 = 4'b0100;
        step();
        req0 = 4'b0000;
        chk("single_busy_c1", 32'(busy0), 32'd1);
        chk("single_qv_c1", 32'(qv0), 32'd1);
        step();
        chk("single_busy_c2", 32'(busy0), 32'd1);
        chk("single_qv_c2", 32'(qv0), 32'd0);
        chk("single_gnt_c2", 32'(gnt0), 32'd0);
        step();
        chk("single_busy_c3", 32'(busy0), 32'd1);
        step();
        chk("single_busy_c4", 32'(busy0), 32'd0);
        chk("single_q_hold", 32'(q0), 32'hA5);
        chk("single_owner_hold", 32'(owner0), 32'd2);
        wait_idle();

        // Reset pulse so rotation starts from pointer 0.
        rst = 1'b0;
        #1;
        chk("pulse_q_clear", 32'(q0), 32'd0);
        step();
        rst = 1'b1;

        // Rotation with all requests held.
        exp0.push_back(mk(4'b0001, 8'h11, 2'd0, -1));
        exp0.push_back(mk(4'b0010, 8'h22, 2'd1, 4));
        exp0.push_back(mk(4'b0100, 8'hA5, 2'd2, 4));
        exp0.push_back(mk(4'b1000, 8'h44, 2'd3, 4));
        exp0.push_back(mk(4'b0001, 8'h11, 2'd0, 4));
        req0 = 4'b1111;
        repeat (17) step();
        req0 = 4'b0000;
`ifdef RR_GNT_CNT_EN
        chk("rot_gnt_cnt", 32'(gcnt0), 32'd5);
`endif
        wait_idle();

        // Skip rule: after granting 1, requesters {3,1,0} continue.
        exp0.push_back(mk(4'b0010, 8'h22, 2'd1, -1));
        exp0.push_back(mk(4'b1000, 8'h44, 2'd3, 4));
        exp0.push_back(mk(4'b0001, 8'h11, 2'd0, 4));
        exp0.push_back(mk(4'b0010, 8'h22, 2'd1, 4));
        req0 = 4'b0010;
        step();
        req0 = 4'b1011;
        repeat (12) step();
        req0 = 4'b0000;
        wait_idle();

        // Reset asserted during COOL.
        exp0.push_back(mk(4'b0100, 8'hA5, 2'd2, -1));
        req0 = 4'b0100;
        step();
        req0 = 4'b0000;
        step();
        chk("midrst_in_cool", 32'(busy0), 32'd1);
        rst = 1'b0;
        #1;
        chk("midrst_busy", 32'(busy0), 32'd0);
        chk("midrst_q", 32'(q0), 32'd0);
        chk("midrst_owner", 32'(owner0), 32'd0);
        chk("midrst_gnt", 32'(gnt0), 32'd0);
        req0 = 4'b1000;
        exp0.push_back(mk(4'b1000, 8'h44, 2'd3, -1));
        step();
        rst = 1'b1;
        step();
        req0 = 4'b0000;
        wait_idle();
        // Pointer wrapped to 0 after granting 3.
        exp0.push_back(mk(4'b0001, 8'h11, 2'd0, -1));
        req0 = 4'b1111;
        step();
        req0 = 4'b0000;
        wait_idle();

        // HOLD=0 instance: grant every 2 cycles, never enters COOL.
        exp1.push_back(mk(4'b0001, 8'h11, 2'd0, -1));
        exp1.push_back(mk(4'b0010, 8'h22, 2'd1, 2));
        exp1.push_back(mk(4'b0100, 8'hA5, 2'd2, 2));
        exp1.push_back(mk(4'b1000, 8'h44, 2'd3, 2));
        req1 = 4'b1111;
        for (int i = 1; i <= 7; i++) begin
            step();
            chk("hold0_busy", 32'(busy1), 32'(i % 2));
        end
        req1 = 4'b0000;
        wait_idle();

        step(); step();
        chk("u0_queue_drained", 32'(exp0.size()), 32'd0);
        chk("u1_queue_drained", 32'(exp1.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/rr_reg_arbiter.md
Name: rr_reg_arbiter

Overview:
- Round-robin arbiter that shares one W-bit register (a bank of D flip-flops) between N requesters.
- Grants one requester at a time, loads that requester's data into the shared register, then enforces a programmable cool-down before the next grant.
- Sits between several producer blocks and a single shared storage register.

Parameters:
- N, 4, number of requesters (N >= 2).
- W, 8, data width per requester and of the shared register.
- HOLD, 2, cool-down cycles after each grant cycle (HOLD >= 0).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset (0 = reset).
- req  input  N  request per requester; bit i = requester i.
- data_in  input  N*W  requester i data at bits [i*W+W-1 : i*W].
- gnt  output  N  one-hot grant pulse, registered.
- q  output  W  shared register contents.
- q_valid  output  1  one-cycle pulse when q was loaded.
- owner  output  clog2(N)  index of the last granted requester.
- busy  output  1  high in GRANT and COOL states.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; gnt=0; q=0; q_valid=0; owner=0; busy=0; priority pointer=0; cool counter=0. The clear takes effect immediately in any state, including mid-GRANT or mid-COOL.
- FSM states: IDLE, GRANT, COOL.
- IDLE:
  - req is sampled only in IDLE.
  - If req==0, stay in IDLE.
  - Otherwise, on the rising edge:
    - the winner is the first set bit searching from the pointer upward with wrap-around (pointer, pointer+1, ..., N-1, 0, ...);
    - gnt <= one-hot(winner);
    - q <= data_in slice of the winner;
    - owner <= winner;
    - q_valid <= 1;
    - pointer <= (winner+1) mod N;
    - state <= GRANT.
- GRANT: lasts exactly 1 cycle.
  - On exit: gnt <= 0 and q_valid <= 0.
  - If HOLD==0: state <= IDLE.
  - Otherwise: state <= COOL with counter <= HOLD-1.
- COOL: counter decrements each cycle; at 0, state <= IDLE. COOL therefore lasts exactly HOLD cycles.
- Grant period with continuous requests: 2+HOLD cycles.
- Latency: req seen high in IDLE at edge k → gnt, q, q_valid, owner valid from edge k to edge k+1.
- Between grants, q and owner hold their values. q changes only on a grant or on reset.
- Handshake:
  - A requester holds req until it sees its gnt bit. It may drop req in the GRANT cycle.
  - If a requester keeps req high, it is served again at its next round-robin turn.
  - req changes during GRANT or COOL are ignored.
- busy = (state != IDLE). It is combinational from the state register.
- Simultaneous requests resolve purely by the pointer. There is no starvation: any held request is served within N grants.
- The pointer wraps from N-1 to 0.

Optional Feature:
- Macro: RR_GNT_CNT_EN.
- When defined:
  - adds output gnt_cnt (16 bits), which increments on every edge that enters GRANT;
  - gnt_cnt saturates at 16'hFFFF;
  - gnt_cnt clears to 0 on reset.
- When undefined: the port and its counter are absent. All other behaviour is identical.

Test Plan:
1. Reset check: drive rst=0 with req=4'b1111, then release. All outputs are 0 while rst=0. After release, the first grant goes to requester 0 (gnt=4'b0001).
2. Single request: req=4'b0100 with data_in slice 2 = 8'hA5. Next edge gives gnt=4'b0100, q=8'hA5, owner=2, and a 1-cycle q_valid pulse. busy stays high for 3 cycles. q stays 8'hA5 afterwards.
3. Rotation: req=4'b1111 held. Grants go to 0,1,2,3,0, spaced 4 cycles apart (HOLD=2). With RR_GNT_CNT_EN defined, gnt_cnt=5 after the fifth grant.
4. Skip rule: after a grant to requester 1, set req=4'b1011. The next grants are 3, then 0, then 1.
5. Reset mid-operation: assert rst=0 during COOL. busy=0, q=0, and state=IDLE immediately. After release with req=4'b1000, the grant goes to requester 3 and the pointer becomes 0.
6. HOLD=0 instance: req=4'b1111 held. Grants go to 0,1,2,3, one every 2 cycles, and COOL is never entered.
